// File: rtl/eth_tx_scheduler.sv
// eth_tx_scheduler: round-robin frame scheduler in front of the TX core.
// Streams payload MSB-first as N-bit symbols, pads short frames, holds IFG.
module eth_tx_scheduler #(
  parameter int N           = 2,
  parameter int NREQ        = 2,
  parameter int MIN_PAYLOAD = 46,
  parameter int IFG_CYCLES  = 96
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [11*NREQ-1:0]   len,
  input  logic [48*NREQ-1:0]   dest_mac,
  input  logic [16*NREQ-1:0]   etype,
  input  logic [8*NREQ-1:0]    src_data,
  input  logic [NREQ-1:0]      src_valid,
  output logic [NREQ-1:0]      src_pop,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      frame_done,
  output logic                 underrun,
  output logic                 busy,
  output logic                 tx_start,
  output logic [47:0]          tx_dest_mac,
  output logic [15:0]          tx_etype,
  input  logic                 tx_hdr_done,
  output logic                 tx_axiiv,
  output logic [N-1:0]         tx_axiid,
  output logic                 tx_last,
  input  logic                 tx_busy
);

  localparam int SPB = 8 / N;
  localparam int SW  = $clog2(SPB);
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [10:0]   MAXLEN   = 11'd1500;
  localparam logic [10:0]   MINLEN   = 11'(MIN_PAYLOAD);
  localparam logic [SW-1:0] SYM_END  = SW'(SPB - 1);
  localparam logic [7:0]    GAP_INIT = 8'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_PAYLOAD,
    S_WAIT,
    S_GAP
  } state_e;

  state_e state_q, state_d;

  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [10:0]     len_q, len_d;
  logic [10:0]     tot_q, tot_d;
  logic [10:0]     byte_q, byte_d;
  logic [SW-1:0]   sym_q, sym_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      gap_q, gap_d;
  logic [47:0]     mac_q, mac_d;
  logic [15:0]     et_q, et_d;
  logic            start_q, start_d;

  logic [IW-1:0]   pick;
  logic [IW-1:0]   k;
  logic            pick_ok;
  logic [10:0]     req_len;
  logic [10:0]     len_cl;

  logic            ld;
  logic [10:0]     ld_idx;
  logic            ld_src;
  logic            last;
  logic            done;
  logic            sv;
  logic [7:0]      sd;

  // first set request at or after rr, wrapping upward
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    k       = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = IW'((int'(rr_q) + i) % NREQ);
      if (!pick_ok && req[k]) begin
        pick_ok = 1'b1;
        pick    = k;
      end
    end
  end

  assign req_len = len[11*int'(pick) +: 11];
  assign len_cl  = (req_len > MAXLEN) ? MAXLEN : req_len;

  assign sv = src_valid[gidx_q];
  assign sd = src_data[8*int'(gidx_q) +: 8];

  assign ld_src = ld && (ld_idx < len_q);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    len_d   = len_q;
    tot_d   = tot_q;
    byte_d  = byte_q;
    sym_d   = sym_q;
    sh_d    = sh_q;
    gap_d   = gap_q;
    mac_d   = mac_q;
    et_d    = et_q;
    start_d = 1'b0;
    ld      = 1'b0;
    ld_idx  = '0;
    last    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|req) state_d = S_ARB;
      end
      S_ARB: begin
        if (pick_ok) begin
          gidx_d  = pick;
          grant_d = NREQ'(1) << pick;
          mac_d   = dest_mac[48*int'(pick) +: 48];
          et_d    = etype[16*int'(pick) +: 16];
          len_d   = len_cl;
          tot_d   = (len_cl > MINLEN) ? len_cl : MINLEN;
          rr_d    = IW'((int'(pick) + 1) % NREQ);
          start_d = 1'b1;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tx_hdr_done) begin
          ld      = 1'b1;
          byte_d  = '0;
          sym_d   = '0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        sh_d  = sh_q << N;
        sym_d = sym_q + 1'b1;
        if (sym_q == SYM_END) begin
          sym_d = '0;
          if (byte_q == tot_q - 11'd1) begin
            last    = 1'b1;
            state_d = S_WAIT;
          end else begin
            ld     = 1'b1;
            ld_idx = byte_q + 11'd1;
            byte_d = byte_q + 11'd1;
          end
        end
      end
      S_WAIT: begin
        if (!tx_busy) begin
          done    = 1'b1;
          gap_d   = GAP_INIT;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        gap_d = gap_q - 8'd1;
        if (gap_q <= 8'd1) begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // bytes past the requested length, or missing ones, go out as zero
    if (ld) sh_d = (ld_src && sv) ? sd : 8'h00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      len_q   <= '0;
      tot_q   <= '0;
      byte_q  <= '0;
      sym_q   <= '0;
      sh_q    <= '0;
      gap_q   <= '0;
      mac_q   <= '0;
      et_q    <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      tot_q   <= tot_d;
      byte_q  <= byte_d;
      sym_q   <= sym_d;
      sh_q    <= sh_d;
      gap_q   <= gap_d;
      mac_q   <= mac_d;
      et_q    <= et_d;
      start_q <= start_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign tx_start    = start_q;
  assign tx_axiiv    = (state_q == S_PAYLOAD);
  assign tx_axiid    = tx_axiiv ? sh_q[7 -: N] : '0;
  assign tx_last     = last;
  assign grant       = grant_q;
  assign tx_dest_mac = mac_q;
  assign tx_etype    = et_q;
  assign frame_done  = done ? grant_q : '0;
  assign src_pop     = (ld_src && sv) ? grant_q : '0;
  assign underrun    = ld_src && !sv;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Bench for eth_tx_scheduler: vector table, hand-written corner sequences
// and randomized frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_eth_tx_scheduler;

  localparam int IFG = 96;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // instance A: N=2
  logic [1:0]  req, src_valid, src_pop, grant, frame_done;
  logic [21:0] len;
  logic [95:0] dest_mac;
  logic [31:0] etype;
  logic [15:0] src_data;
  logic        underrun, busy, tx_start, tx_hdr_done;
  logic        tx_axiiv, tx_last, tx_busy;
  logic [47:0] tx_dest_mac;
  logic [15:0] tx_etype;
  logic [1:0]  tx_axiid;

  // instance B: N=4
  logic [1:0]  req_b, src_valid_b, src_pop_b, grant_b, frame_done_b;
  logic [21:0] len_b;
  logic [95:0] dest_mac_b;
  logic [31:0] etype_b;
  logic [15:0] src_data_b;
  logic        underrun_b, busy_b, tx_start_b, tx_hdr_done_b;
  logic        tx_axiiv_b, tx_last_b, tx_busy_b;
  logic [47:0] tx_dest_mac_b;
  logic [15:0] tx_etype_b;
  logic [3:0]  tx_axiid_b;

  eth_tx_scheduler #(.N(2), .NREQ(2), .MIN_PAYLOAD(46), .IFG_CYCLES(IFG)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .dest_mac(dest_mac),
    .etype(etype), .src_data(src_data), .src_valid(src_valid),
    .src_pop(src_pop), .grant(grant), .frame_done(frame_done),
    .underrun(underrun), .busy(busy), .tx_start(tx_start),
    .tx_dest_mac(tx_dest_mac), .tx_etype(tx_etype),
    .tx_hdr_done(tx_hdr_done), .tx_axiiv(tx_axiiv), .tx_axiid(tx_axiid),
    .tx_last(tx_last), .tx_busy(tx_busy)
  );

  eth_tx_scheduler #(.N(4), .NREQ(2), .MIN_PAYLOAD(46), .IFG_CYCLES(IFG)) dut4 (
    .clk(clk), .rst(rst), .req(req_b), .len(len_b), .dest_mac(dest_mac_b),
    .etype(etype_b), .src_data(src_data_b), .src_valid(src_valid_b),
    .src_pop(src_pop_b), .grant(grant_b), .frame_done(frame_done_b),
    .underrun(underrun_b), .busy(busy_b), .tx_start(tx_start_b),
    .tx_dest_mac(tx_dest_mac_b), .tx_etype(tx_etype_b),
    .tx_hdr_done(tx_hdr_done_b), .tx_axiiv(tx_axiiv_b),
    .tx_axiid(tx_axiid_b), .tx_last(tx_last_b), .tx_busy(tx_busy_b)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // simple TX core: header delay, then busy until CRC after tx_last
  task automatic core_step(input logic st, input logic lst, input int crc,
                           inout int s, inout int c,
                           inout logic hd, inout logic bz);
    if (!rst) begin
      s = 0; hd = 1'b0; bz = 1'b0;
    end else begin
      case (s)
        0: if (st) begin bz = 1'b1; c = 8; s = 1; end
        1: begin c--; if (c == 0) begin hd = 1'b1; s = 2; end end
        2: begin hd = 1'b0; s = 3; end
        3: if (lst) begin c = crc; s = 4; end
        default: begin c--; if (c == 0) begin bz = 1'b0; s = 0; end end
      endcase
    end
  endtask

  initial begin : core_a
    int s, c;
    s = 0; c = 0; tx_hdr_done = 1'b0; tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      core_step(tx_start, tx_last, 16, s, c, tx_hdr_done, tx_busy);
    end
  end

  initial begin : core_b
    int s, c;
    s = 0; c = 0; tx_hdr_done_b = 1'b0; tx_busy_b = 1'b0;
    forever begin
      @(posedge clk); #1;
      core_step(tx_start_b, tx_last_b, 8, s, c, tx_hdr_done_b, tx_busy_b);
    end
  end

  // requester sources and reference model state
  int         ptr[2];
  int         lens[2];
  int         drop[2];
  logic [7:0] base[2];
  logic [47:0] macs[2];
  logic [15:0] ets[2];
  int          rr_m;

  function automatic logic [7:0] dat(input int r, input int kk);
    return 8'(kk) + base[r];
  endfunction

  task automatic drive_src();
    for (int r = 0; r < 2; r++) begin
      src_data[8*r +: 8] = dat(r, ptr[r]);
      src_valid[r]       = (ptr[r] != drop[r]);
      len[11*r +: 11]    = 11'(lens[r]);
    end
  endtask

  logic [1:0]  r_g, r_done;
  int          r_pop, r_bad, r_und, r_vc, r_vfirst, r_vlast;
  int          r_lastcnt, r_lastpos, r_start, t_req, t_done;
  logic [47:0] r_mac;
  logic [15:0] r_et;
  logic [7:0]  rx[$];

  task automatic run_frame(input logic [1:0] rq, input bit hold);
    logic [7:0] acc;
    logic [1:0] popd, gm;
    bit         undd, fin;
    int         ns;
    req = rq; t_req = cyc;
    r_g = '0; r_done = '0; r_pop = 0; r_bad = 0; r_und = 0;
    r_vc = 0; r_vfirst = 0; r_vlast = 0; r_lastcnt = 0;
    r_lastpos = 0; r_start = -1; r_mac = '0; r_et = '0;
    rx.delete();
    acc = '0; ns = 0; fin = 0;
    for (int i = 0; i < 20000 && !fin; i++) begin
      @(negedge clk);
      if (tx_start && r_start < 0) begin
        r_start = cyc; r_g = grant; r_mac = tx_dest_mac; r_et = tx_etype;
      end
      if (tx_axiiv) begin
        if (r_vc == 0) r_vfirst = cyc;
        r_vlast = cyc;
        r_vc++;
        acc = {acc[5:0], tx_axiid};
        ns++;
        if (ns == 4) begin rx.push_back(acc); ns = 0; end
        if (tx_last) begin r_lastcnt++; r_lastpos = r_vc; end
      end else if (tx_last) begin
        r_lastcnt++;
      end
      popd = src_pop; undd = underrun; gm = grant;
      r_pop += $countones(src_pop & grant);
      r_bad += $countones(src_pop & ~grant);
      r_und += int'(underrun);
      if (frame_done != '0) begin
        r_done = frame_done; t_done = cyc; fin = 1;
      end
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++)
        if (popd[r] || (undd && gm[r])) ptr[r]++;
      if (fin) begin
        for (int r = 0; r < 2; r++) if (r_done[r]) ptr[r] = 0;
        if (!hold) req = '0;
      end
      drive_src();
    end
    if (!fin) begin
      n_chk++; n_fail++;
      $display("FAIL frame_timeout: got no frame_done expected one");
    end
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    do begin @(negedge clk); i++; end while (busy && i < 1000);
    if (busy) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic do_frame(input string tag, input logic [1:0] rq,
                          input bit hold, input bit idle_first,
                          input logic [1:0] eg, input int epop,
                          input int eund, input int evc, input int elat);
    int g, lc, tot, bad, pd;
    logic [7:0] e;
    if (idle_first) wait_idle();
    pd = t_done;
    drive_src();
    run_frame(rq, hold);
    g = eg[1] ? 1 : 0;
    chk({tag, ".grant"}, r_g, eg);
    chk({tag, ".pops"}, r_pop, epop);
    chk({tag, ".foreign_pops"}, r_bad, 0);
    chk({tag, ".underrun"}, r_und, eund);
    chk({tag, ".valid_cycles"}, r_vc, evc);
    chk({tag, ".valid_span"}, r_vlast - r_vfirst + 1, evc);
    chk({tag, ".last_count"}, r_lastcnt, 1);
    chk({tag, ".last_pos"}, r_lastpos, evc);
    chk({tag, ".frame_done"}, r_done, eg);
    chk({tag, ".dest_mac"}, r_mac, macs[g]);
    chk({tag, ".etype"}, r_et, ets[g]);
    if (elat >= 0)
      chk({tag, ".start_lat"}, r_start - (idle_first ? t_req : pd), elat);
    lc  = (lens[g] > 1500) ? 1500 : lens[g];
    tot = (lc > 46) ? lc : 46;
    bad = (rx.size() != tot) ? 1 : 0;
    for (int kk = 0; kk < rx.size(); kk++) begin
      e = (kk < lc && kk != drop[g]) ? dat(g, kk) : 8'h00;
      if (rx[kk] != e) bad++;
    end
    chk({tag, ".bytes"}, bad, 0);
    rr_m = (g + 1) % 2;
  endtask

  typedef struct {
    logic [1:0] rq;
    int         l0;
    int         l1;
    int         d0;
    int         d1;
    logic [1:0] eg;
    int         epop;
    int         eund;
    int         evc;
  } vec_t;

  vec_t tbl[9];

  task automatic pad_n4();
    int vc, pops, lastc, bad, ns, nb;
    logic [7:0] acc, e;
    bit fin;
    vc = 0; pops = 0; lastc = 0; bad = 0; ns = 0; nb = 0;
    acc = '0; fin = 0;
    req_b = 2'b01;
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(negedge clk);
      if (tx_axiiv_b) begin
        vc++;
        acc = {acc[3:0], tx_axiid_b};
        ns++;
        if (ns == 2) begin
          e = (nb < 10) ? 8'h5A : 8'h00;
          if (acc != e) bad++;
          nb++; ns = 0;
        end
      end
      pops  += $countones(src_pop_b);
      lastc += int'(tx_last_b);
      if (frame_done_b != '0) fin = 1;
      @(posedge clk); #1;
      if (fin) req_b = '0;
    end
    chk("n4_pad.done", int'(fin), 1);
    chk("n4_pad.valid_cycles", vc, 92);
    chk("n4_pad.pops", pops, 10);
    chk("n4_pad.bytes_seen", nb, 46);
    chk("n4_pad.byte_errors", bad, 0);
    chk("n4_pad.last_count", lastc, 1);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: got no finish expected finish within 1ms");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int i, lc, tot, dr, eund;
    logic [1:0] rq, eg;
    bit ok;

    tbl[0] = '{2'b01, 60,   0,   -1,  -1, 2'b01, 60,   0, 240};
    tbl[1] = '{2'b01, 10,   0,   -1,  -1, 2'b01, 10,   0, 184};
    tbl[2] = '{2'b10, 0,    2000, -1, -1, 2'b10, 1500, 0, 6000};
    tbl[3] = '{2'b01, 50,   0,    5,  -1, 2'b01, 49,   1, 200};
    tbl[4] = '{2'b11, 46,   47,  -1,  -1, 2'b10, 47,   0, 188};
    tbl[5] = '{2'b11, 1,    3,   -1,  -1, 2'b01, 1,    0, 184};
    tbl[6] = '{2'b10, 5,    1501, -1, 700, 2'b10, 1499, 1, 6000};
    tbl[7] = '{2'b01, 46,   0,    45, -1, 2'b01, 45,   1, 184};
    tbl[8] = '{2'b10, 0,    20,  -1,  -1, 2'b10, 20,   0, 184};

    macs[0] = 48'h02_00_00_00_00_01; ets[0] = 16'h0800;
    macs[1] = 48'h02_00_00_00_00_02; ets[1] = 16'h86DD;
    dest_mac = {macs[1], macs[0]};
    etype    = {ets[1], ets[0]};
    dest_mac_b  = {48'h0, 48'hAABB_CCDD_EEFF};
    etype_b     = {16'h0, 16'h0806};
    src_data_b  = 16'h5A5A;
    src_valid_b = 2'b11;
    len_b       = {11'd0, 11'd10};
    req_b       = '0;
    req = '0;
    for (int r = 0; r < 2; r++) begin
      ptr[r] = 0; lens[r] = 0; drop[r] = -1; base[r] = '0;
    end
    drive_src();
    rr_m = 0; t_done = 0;

    #3 rst = 1'b0;
    #1;
    chk("reset.ctrl",
        {busy, tx_start, tx_axiiv, tx_last, underrun,
         grant, frame_done, src_pop, tx_axiid}, 0);
    chk("reset.dest_mac", tx_dest_mac, 0);
    chk("reset.etype", tx_etype, 0);
    chk("reset.ctrl_n4",
        {busy_b, tx_start_b, tx_axiiv_b, underrun_b, grant_b}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    pad_n4();

    for (int v = 0; v < 9; v++) begin
      lens[0] = tbl[v].l0;  lens[1] = tbl[v].l1;
      drop[0] = tbl[v].d0;  drop[1] = tbl[v].d1;
      base[0] = 8'(16 * v); base[1] = 8'(8'h80 + v);
      do_frame($sformatf("vec%0d", v), tbl[v].rq, 1'b0, 1'b1,
               tbl[v].eg, tbl[v].epop, tbl[v].eund, tbl[v].evc, 2);
    end

    // held dual request: rotation and inter-frame gap
    lens[0] = 12; lens[1] = 13; drop[0] = -1; drop[1] = -1;
    do_frame("rr0", 2'b11, 1'b1, 1'b1, 2'b01, 12, 0, 184, 2);
    do_frame("rr1", 2'b11, 1'b1, 1'b0, 2'b10, 13, 0, 184, IFG + 2);
    do_frame("rr2", 2'b11, 1'b1, 1'b0, 2'b01, 12, 0, 184, IFG + 2);
    req = '0;

    // reset in the middle of a payload
    wait_idle();
    lens[0] = 30; lens[1] = 30; ptr[0] = 0; ptr[1] = 0;
    drive_src();
    req = 2'b01;
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = tx_axiiv;
    end
    chk("rst_mid.reached_payload", int'(ok), 1);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    req = 2'b11;
    #1;
    chk("rst_mid.ctrl",
        {busy, tx_start, tx_axiiv, tx_last, underrun,
         grant, frame_done, src_pop, tx_axiid}, 0);
    chk("rst_mid.dest_mac", tx_dest_mac, 0);
    ptr[0] = 0; ptr[1] = 0;
    drive_src();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    do_frame("rst_regrant", 2'b11, 1'b0, 1'b0, 2'b01, 30, 0, 184, -1);

    // randomized frames against the reference model
    for (i = 0; i < 15; i++) begin
      rq = 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        if (i % 7 == 3) lens[r] = $urandom_range(1490, 1600);
        else            lens[r] = $urandom_range(1, 80);
        drop[r] = ($urandom_range(0, 3) == 0) ?
                  $urandom_range(0, lens[r] - 1) : -1;
        base[r] = 8'($urandom);
      end
      eg = rq[rr_m] ? (2'b01 << rr_m) : (2'b01 << (1 - rr_m));
      dr = eg[1] ? 1 : 0;
      lc  = (lens[dr] > 1500) ? 1500 : lens[dr];
      tot = (lc > 46) ? lc : 46;
      eund = (drop[dr] >= 0 && drop[dr] < lc) ? 1 : 0;
      do_frame($sformatf("rnd%0d", i), rq, 1'b0, 1'b1,
               eg, lc - eund, eund, tot * 4, 2);
    end

    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
